// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction port (imem) and a data port
// (dmem) share one memory port. The winner is chosen combinationally while
// idle, so a ready memory can finish a transfer in the request cycle. The
// owner is locked while the memory stalls. Data normally wins; a starvation
// counter gives imem the memory after STARVE_LIMIT data grants in a row.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,

  input  logic                  dmem_valid_i,
  output logic                  dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_we_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,

  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  output logic [1:0]            grant_o
);

  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  // Owner codes double as the grant_o encoding.
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] starve_cnt;
  logic [1:0]           owner;        // requester connected to memory this cycle
  logic                 owner_valid;  // that requester is still asking

  // Arbitration: pick a winner while idle, otherwise stay on the locked owner.
  always_comb begin
    owner       = OWN_NONE;
    owner_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dmem_valid_i && (!imem_valid_i || starve_cnt != CNT_MAX)) begin
          owner = OWN_D;
        end else if (imem_valid_i) begin
          owner = OWN_I;
        end
      end
      BUSY_I:  owner = OWN_I;
      BUSY_D:  owner = OWN_D;
      default: owner = OWN_NONE;
    endcase
    if (owner == OWN_I) begin
      owner_valid = imem_valid_i;
    end else if (owner == OWN_D) begin
      owner_valid = dmem_valid_i;
    end
  end

  // State register; reset abandons any in-flight transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: lock the owner only while its request waits on a stalled
  // memory; completion or a dropped request both return to arbitration.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE: begin
        if (owner_valid && !mem_ready_i) begin
          state_next = (owner == OWN_I) ? BUSY_I : BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (owner_valid && !mem_ready_i) begin
          state_next = state_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output mux: route the owner's payload out and the memory's response back.
  // Everything is forced quiet while reset is held.
  always_comb begin
    grant_o      = OWN_NONE;
    mem_valid_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = '0;
    imem_ready_o = 1'b0;
    dmem_ready_o = 1'b0;
    imem_rdata_o = '0;
    dmem_rdata_o = '0;
    if (rst_n) begin
      case (owner)
        OWN_I: begin
          grant_o      = OWN_I;
          mem_valid_o  = imem_valid_i;
          mem_addr_o   = imem_addr_i;
          mem_wdata_o  = imem_wdata_i;
          mem_we_o     = imem_we_i;
          imem_ready_o = imem_valid_i & mem_ready_i;
          imem_rdata_o = mem_rdata_i;
        end
        OWN_D: begin
          grant_o      = OWN_D;
          mem_valid_o  = dmem_valid_i;
          mem_addr_o   = dmem_addr_i;
          mem_wdata_o  = dmem_wdata_i;
          mem_we_o     = dmem_we_i;
          dmem_ready_o = dmem_valid_i & mem_ready_i;
          dmem_rdata_o = mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: counts data transfers completed while imem waits,
  // saturating; any imem completion or an idle imem clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!imem_valid_i || imem_ready_o) begin
      starve_cnt <= '0;
    end else if (dmem_ready_o && starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: consecutive dmem grants tolerated while imem waits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports imem_valid_i  input  1, imem_ready_o  output  1: instruction requester handshake.
REQ-007 SHALL have ports imem_addr_i  input  ADDR_WIDTH, imem_wdata_i  input  DATA_WIDTH, imem_we_i  input  4, imem_rdata_o  output  DATA_WIDTH.
REQ-008 SHALL have ports dmem_valid_i  input  1, dmem_ready_o  output  1: data requester handshake.
REQ-009 SHALL have ports dmem_addr_i  input  ADDR_WIDTH, dmem_wdata_i  input  DATA_WIDTH, dmem_we_i  input  4, dmem_rdata_o  output  DATA_WIDTH.
REQ-010 SHALL have ports mem_valid_o  output  1, mem_ready_i  input  1: shared memory handshake.
REQ-011 SHALL have ports mem_addr_o  output  ADDR_WIDTH, mem_wdata_o  output  DATA_WIDTH, mem_we_o  output  4, mem_rdata_i  input  DATA_WIDTH.
REQ-012 SHALL have port grant_o  output  2  current owner: 2'b00 none, 2'b01 imem, 2'b10 dmem.

Function
REQ-013 SHALL implement FSM with states IDLE, BUSY_I, BUSY_D.
REQ-014 Handshake: requester holds valid and payload stable until its ready is high for one cycle; transfer completes in that cycle.
REQ-015 IDLE, no valid: mem_valid_o=0, both ready=0, grant_o=00, mem_addr_o/wdata_o/we_o=0.
REQ-016 IDLE, valid present: winner selected combinationally, its payload driven to mem_* and mem_valid_o=1 in the same cycle (zero arbitration latency).
REQ-017 Winner rule: dmem wins when both valid, unless starve_cnt==STARVE_LIMIT, then imem wins.
REQ-018 IDLE with mem_ready_i=1 in selection cycle: winner's ready=1 that cycle, FSM stays IDLE.
REQ-019 IDLE with mem_ready_i=0: next state BUSY_I or BUSY_D per winner; owner locked.
REQ-020 BUSY_x: mux locked to owner regardless of other valid; grant_o shows owner; owner ready = mem_ready_i; non-owner ready=0.
REQ-021 BUSY_x with mem_ready_i=1: transfer completes, next state IDLE; new arbitration occurs the following cycle.
REQ-022 BUSY_x with owner valid dropped and mem_ready_i=0: mem_valid_o=0, ready=0, next state IDLE (abort, no transfer).
REQ-023 Owner rdata output = mem_rdata_i; non-owner rdata output = 0; both rdata outputs = 0 in IDLE with no winner.
REQ-024 starve_cnt: $clog2(STARVE_LIMIT+1) bits; increments on each completed dmem transfer while imem_valid_i=1; saturates at STARVE_LIMIT.
REQ-025 starve_cnt clears to 0 on any completed imem transfer or any cycle imem_valid_i=0.
REQ-026 Non-owner valid asserted mid-transfer SHALL not affect current transfer; it is considered only at the next IDLE arbitration.
REQ-027 mem_ready_i while mem_valid_o=0 SHALL be ignored (no state change, no ready pulse).

Reset
REQ-028 rst_n=0 at a rising clk edge: FSM->IDLE, starve_cnt->0, regardless of in-flight transfer.
REQ-029 While rst_n=0: mem_valid_o=0, imem_ready_o=0, dmem_ready_o=0, grant_o=00, all data/addr/we outputs 0.
REQ-030 First arbitration permitted in the first cycle with rst_n=1.

Verification
REQ-031 Only imem_valid=1, addr=0x100, mem_ready_i=1 same cycle -> mem_addr_o=0x100, imem_ready_o=1 same cycle, grant_o=01, FSM stays IDLE.
REQ-032 Both valid, mem_ready_i delayed 3 cycles -> dmem owns for 4 cycles, imem_ready_o=0 throughout, imem granted the cycle after dmem completes.
REQ-033 Both valid continuously, mem_ready_i=1 each owned cycle, STARVE_LIMIT=4 -> 4 dmem transfers then 1 imem transfer, pattern repeats.
REQ-034 BUSY_D, dmem_valid drops before mem_ready_i -> mem_valid_o=0 same cycle, IDLE next cycle, no dmem_ready_o pulse.
REQ-035 rst_n=0 during BUSY_I with mem_ready_i=0 -> next cycle grant_o=00, mem_valid_o=0, starve_cnt=0.
REQ-036 mem_rdata_i=0xDEADBEEF during dmem read completion -> dmem_rdata_o=0xDEADBEEF, imem_rdata_o=0.
